// File: rtl/sram_array_ctrl_pkg.sv
// Shared constants and FSM state type for the SRAM array controller.
// Default geometry matches a 512 x 77 single-port-pair SRAM macro.
package sram_array_ctrl_pkg;

  localparam int DEPTH_DEF = 512;
  localparam int WIDTH_DEF = 77;
  localparam int AW_DEF    = 9;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sram_array_ctrl_if.sv
// Read request, read response and write handshakes of the SRAM array controller.
// The controller takes the slave side; the client takes the master side.
interface sram_array_ctrl_if
  import sram_array_ctrl_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int WIDTH = WIDTH_DEF
);

  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    req_addr;

  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;

  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport slave (
    input  req_valid, req_addr, resp_ready, wr_valid, wr_addr, wr_data,
    output req_ready, resp_valid, resp_data, wr_ready
  );

  modport master (
    output req_valid, req_addr, resp_ready, wr_valid, wr_addr, wr_data,
    input  req_ready, resp_valid, resp_data, wr_ready
  );

endinterface

// File: rtl/sram_resp_fifo.sv
// Two-entry response buffer; head entry is presented on o_data while o_valid.
// A push into a full buffer is only taken when the head pops in the same cycle.
module sram_resp_fifo
  import sram_array_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;

  logic w_pop;
  logic w_push;

  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_push = i_push & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/sram_array_ctrl.sv
// SRAM array controller: zero-fill sweep after reset, then write pass-through
// and credit-limited reads with a two-entry response buffer.
module sram_array_ctrl
  import sram_array_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  sram_array_ctrl_if.slave bus,
  output logic             o_init_done,
  output logic             o_sram_r_en,
  output logic [AW-1:0]    o_sram_r_addr,
  input  logic [WIDTH-1:0] i_sram_r_data,
  output logic             o_sram_w_en,
  output logic [AW-1:0]    o_sram_w_addr,
  output logic [WIDTH-1:0] o_sram_w_data,
  output logic             o_sram_w_mask
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        r_state;
  logic [AW-1:0] r_clr_cnt;
  logic          r_init_done;
  logic          r_inflight;

  logic          w_run;
  logic          w_accept;
  logic          w_pop;
  logic          w_fifo_valid;
  logic [1:0]    w_fifo_count;
  logic [2:0]    w_used;
  logic          w_req_ready;

  assign w_run = (r_state == RUN);
  assign w_pop = w_fifo_valid & bus.resp_ready;

  // A head leaving this cycle frees its slot in time for the data of a
  // request accepted now, which keeps full throughput with resp_ready high.
  assign w_used      = 3'(r_inflight) + {1'b0, w_fifo_count} - 3'(w_pop);
  assign w_req_ready = w_run & (w_used < 3'd2);
  assign w_accept    = bus.req_valid & w_req_ready;

  assign bus.req_ready = w_req_ready;
  assign bus.wr_ready  = w_run;

  assign o_sram_r_en   = w_accept;
  assign o_sram_r_addr = bus.req_addr;

  // The sweep write is held off while reset is asserted.
  assign o_sram_w_en   = w_run ? bus.wr_valid : i_reset_n;
  assign o_sram_w_addr = w_run ? bus.wr_addr  : r_clr_cnt;
  assign o_sram_w_data = w_run ? bus.wr_data  : '0;
  assign o_sram_w_mask = 1'b1;

  assign o_init_done = r_init_done;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= INIT;
      r_clr_cnt   <= '0;
      r_init_done <= 1'b0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (r_state == INIT) begin
        r_clr_cnt <= r_clr_cnt + AW'(1);
        if (r_clr_cnt == LAST_ADDR) begin
          r_state     <= RUN;
          r_init_done <= 1'b1;
          r_clr_cnt   <= '0;
        end
      end
    end
  end

  sram_resp_fifo #(
    .WIDTH (WIDTH)
  ) u_resp_fifo (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_push      (r_inflight),
    .i_push_data (i_sram_r_data),
    .i_pop       (w_pop),
    .o_valid     (w_fifo_valid),
    .o_data      (bus.resp_data),
    .o_count     (w_fifo_count)
  );

  assign bus.resp_valid = w_fifo_valid;

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Self-checking bench for sram_array_ctrl with a behavioural SRAM model whose
// read data follows the address latched on the read enable.
module tb_sram_array_ctrl;
  import sram_array_ctrl_pkg::*;

  localparam int DEPTH = DEPTH_DEF;
  localparam int WIDTH = WIDTH_DEF;
  localparam int AW    = AW_DEF;

  logic             clock;
  logic             reset_n;
  logic             o_init_done;
  logic             o_sram_r_en;
  logic [AW-1:0]    o_sram_r_addr;
  logic [WIDTH-1:0] i_sram_r_data;
  logic             o_sram_w_en;
  logic [AW-1:0]    o_sram_w_addr;
  logic [WIDTH-1:0] o_sram_w_data;
  logic             o_sram_w_mask;
  logic             fill;

  int checks = 0;
  int errors = 0;

  sram_array_ctrl_if #(.AW(AW), .WIDTH(WIDTH)) bus ();

  sram_array_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .i_clock       (clock),
    .i_reset_n     (reset_n),
    .bus           (bus),
    .o_init_done   (o_init_done),
    .o_sram_r_en   (o_sram_r_en),
    .o_sram_r_addr (o_sram_r_addr),
    .i_sram_r_data (i_sram_r_data),
    .o_sram_w_en   (o_sram_w_en),
    .o_sram_w_addr (o_sram_w_addr),
    .o_sram_w_data (o_sram_w_data),
    .o_sram_w_mask (o_sram_w_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM model; the fill pulse loads a nonzero pattern so the sweep is observable.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdAddrQ;

  always @(posedge clock) begin
    if (fill) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(32'hA5A5_0000 + i);
    end else if (o_sram_w_en && o_sram_w_mask) begin
      mem[o_sram_w_addr] <= o_sram_w_data;
    end
    if (o_sram_r_en) rdAddrQ <= o_sram_r_addr;
  end

  assign i_sram_r_data = mem[rdAddrQ];

  typedef struct {
    logic             wr;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr;
    logic             wr1;
    logic [WIDTH-1:0] w1data;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One read transaction at a negedge: optional same-cycle write, optional
  // write to the read address one cycle later, response checked two cycles on.
  task automatic applyStimulus(input vec_t v, input int idx);
    bus.wr_valid  = v.wr;
    bus.wr_addr   = v.waddr;
    bus.wr_data   = v.wdata;
    bus.req_valid = 1'b1;
    bus.req_addr  = v.raddr;
    #1;
    checkOutput($sformatf("v%0d req_ready", idx), WIDTH'(bus.req_ready), WIDTH'(1));
    checkOutput($sformatf("v%0d sram_w_en", idx), WIDTH'(o_sram_w_en), WIDTH'(v.wr));
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.wr_valid  = v.wr1;
    bus.wr_addr   = v.raddr;
    bus.wr_data   = v.w1data;
    #1;
    checkOutput($sformatf("v%0d early resp_valid", idx), WIDTH'(bus.resp_valid), WIDTH'(0));
    @(negedge clock);
    bus.wr_valid = 1'b0;
    #1;
    checkOutput($sformatf("v%0d resp_valid", idx), WIDTH'(bus.resp_valid), WIDTH'(1));
    checkOutput($sformatf("v%0d resp_data", idx), bus.resp_data, v.exp);
    @(negedge clock);
  endtask

  // Watches a clear sweep from the sample just after reset release until init_done.
  task automatic sweepMonitor(output int wenCnt, output int addrErr, output int dataErr,
                              output int busy, output int respSeen, output int doneIdx);
    wenCnt = 0; addrErr = 0; dataErr = 0; busy = 0; respSeen = 0; doneIdx = -1;
    for (int k = 0; k < 600 && doneIdx < 0; k++) begin
      if (o_init_done) begin
        doneIdx = k;
      end else begin
        if (o_sram_w_en) begin
          if (o_sram_w_addr !== AW'(wenCnt)) addrErr++;
          if (o_sram_w_data !== '0 || o_sram_w_mask !== 1'b1) dataErr++;
          wenCnt++;
        end
        if (bus.req_ready || bus.wr_ready || o_sram_r_en) busy++;
        if (bus.resp_valid) respSeen++;
        @(negedge clock);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wenCnt, addrErr, dataErr, busy, respSeen, doneIdx;
    int nextAddr, got, accDone, holdBad;
    logic [WIDTH-1:0] ones;

    ones = '1;
    vecs[0] = '{1'b1, 9'd5,   77'h1ABC, 9'd7,   1'b0, 77'h0,  77'h0};
    vecs[1] = '{1'b0, 9'd0,   77'h0,    9'd5,   1'b0, 77'h0,  77'h1ABC};
    vecs[2] = '{1'b0, 9'd0,   77'h0,    9'd6,   1'b0, 77'h0,  77'h0};
    vecs[3] = '{1'b1, 9'd9,   77'h11,   9'd3,   1'b0, 77'h0,  77'h0};
    vecs[4] = '{1'b1, 9'd9,   77'h77,   9'd9,   1'b0, 77'h0,  77'h77};
    vecs[5] = '{1'b0, 9'd0,   77'h0,    9'd9,   1'b1, 77'h88, 77'h77};
    vecs[6] = '{1'b0, 9'd0,   77'h0,    9'd9,   1'b0, 77'h0,  77'h88};
    vecs[7] = '{1'b1, 9'd511, ones,     9'd0,   1'b0, 77'h0,  77'h0};
    vecs[8] = '{1'b1, 9'd0,   77'h3,    9'd511, 1'b0, 77'h0,  ones};
    vecs[9] = '{1'b0, 9'd0,   77'h0,    9'd0,   1'b0, 77'h0,  77'h3};

    reset_n        = 1'b0;
    fill           = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.resp_ready = 1'b1;
    bus.wr_valid   = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;

    @(negedge clock);
    fill = 1'b0;
    #1;
    checkOutput("reset resp_valid", WIDTH'(bus.resp_valid), WIDTH'(0));
    checkOutput("reset init_done",  WIDTH'(o_init_done),    WIDTH'(0));
    checkOutput("reset req_ready",  WIDTH'(bus.req_ready),  WIDTH'(0));
    checkOutput("reset wr_ready",   WIDTH'(bus.wr_ready),   WIDTH'(0));
    checkOutput("reset sram_r_en",  WIDTH'(o_sram_r_en),    WIDTH'(0));
    checkOutput("reset sram_w_en",  WIDTH'(o_sram_w_en),    WIDTH'(0));

    @(negedge clock);
    reset_n = 1'b1;
    #1;
    sweepMonitor(wenCnt, addrErr, dataErr, busy, respSeen, doneIdx);
    checkOutput("sweep write count",   WIDTH'(wenCnt),  WIDTH'(DEPTH));
    checkOutput("sweep address errors", WIDTH'(addrErr), WIDTH'(0));
    checkOutput("sweep data errors",    WIDTH'(dataErr), WIDTH'(0));
    checkOutput("sweep ready leaks",    WIDTH'(busy),    WIDTH'(0));
    checkOutput("init_done cycle",      WIDTH'(doneIdx), WIDTH'(DEPTH));
    checkOutput("post-sweep sram_w_en", WIDTH'(o_sram_w_en), WIDTH'(0));

    @(negedge clock);
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);
    checkOutput("init_done held", WIDTH'(o_init_done), WIDTH'(1));

    for (int i = 0; i < 8; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = AW'(i);
      bus.wr_data  = WIDTH'(32'h100 + i);
      @(negedge clock);
    end
    bus.wr_valid = 1'b0;

    // Back-to-back reads with the response side stalled.
    bus.resp_ready = 1'b0;
    nextAddr = 0;
    holdBad  = 0;
    for (int c = 0; c < 6; c++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = AW'(nextAddr);
      #1;
      if (bus.req_ready) nextAddr++;
      if (bus.resp_valid && bus.resp_data !== WIDTH'(32'h100)) holdBad++;
      @(negedge clock);
    end
    checkOutput("stalled acceptances", WIDTH'(nextAddr), WIDTH'(2));
    checkOutput("stalled head stable", WIDTH'(holdBad), WIDTH'(0));
    checkOutput("stalled resp_valid",  WIDTH'(bus.resp_valid), WIDTH'(1));

    bus.resp_ready = 1'b1;
    got     = 0;
    accDone = -1;
    for (int c = 0; c < 40 && got < 8; c++) begin
      bus.req_valid = (nextAddr < 8);
      bus.req_addr  = AW'(nextAddr);
      #1;
      if (bus.req_valid && bus.req_ready) begin
        nextAddr++;
        if (nextAddr == 8) accDone = c;
      end
      if (bus.resp_valid) begin
        checkOutput($sformatf("order resp %0d", got), bus.resp_data, WIDTH'(32'h100 + got));
        got++;
      end
      @(negedge clock);
    end
    bus.req_valid = 1'b0;
    checkOutput("responses returned",  WIDTH'(got),     WIDTH'(8));
    checkOutput("no-bubble throughput", WIDTH'(accDone), WIDTH'(5));

    // Fill the buffer to two entries, then reset in the middle of the cycle.
    bus.resp_ready = 1'b0;
    nextAddr = 1;
    for (int c = 0; c < 4; c++) begin
      bus.req_valid = (nextAddr < 3);
      bus.req_addr  = AW'(nextAddr);
      #1;
      if (bus.req_valid && bus.req_ready) nextAddr++;
      @(negedge clock);
    end
    bus.req_valid = 1'b0;
    #1;
    checkOutput("pre-reset acceptances", WIDTH'(nextAddr), WIDTH'(3));
    checkOutput("pre-reset head", bus.resp_data, WIDTH'(32'h101));
    checkOutput("pre-reset req_ready", WIDTH'(bus.req_ready), WIDTH'(0));
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset resp_valid", WIDTH'(bus.resp_valid), WIDTH'(0));
    checkOutput("async reset init_done",  WIDTH'(o_init_done),    WIDTH'(0));
    checkOutput("async reset wr_ready",   WIDTH'(bus.wr_ready),   WIDTH'(0));
    @(negedge clock);
    @(negedge clock);
    bus.resp_ready = 1'b1;
    reset_n = 1'b1;
    #1;
    checkOutput("restart sram_w_en", WIDTH'(o_sram_w_en), WIDTH'(1));
    checkOutput("restart address",   WIDTH'(o_sram_w_addr), WIDTH'(0));
    sweepMonitor(wenCnt, addrErr, dataErr, busy, respSeen, doneIdx);
    checkOutput("resweep write count",  WIDTH'(wenCnt),   WIDTH'(DEPTH));
    checkOutput("resweep address errors", WIDTH'(addrErr), WIDTH'(0));
    checkOutput("stale responses seen", WIDTH'(respSeen), WIDTH'(0));
    checkOutput("resweep init_done cycle", WIDTH'(doneIdx), WIDTH'(DEPTH));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
